// File: rtl/clock_enable_sequencer.sv
// Purpose: derives bus phase, c1/c3 quadrature, CCK, E-clock and CPU enables from clk28m.
// Latency: every output is a decode of registered p/e_cnt/mode, so a change shows the cycle after the counter edge.
// Backpressure: none; the block is free-running, and turbo requests wait for the next bus-cycle boundary.
// Ports: clk28m, reset (sync, active-high), turbo in; phase, clk7m, c1, c3, clk_en, cck, cck_en,
//        eclk, cpu_en and turbo_active out.
module clock_enable_sequencer #(
    parameter int CLK_DIV   = 4,
    parameter int ECLK_DIV  = 10,
    parameter int TURBO_DIV = 2
) (
    input  logic                clk28m,
    input  logic                reset,
    input  logic                turbo,
    output logic [CLK_DIV-1:0]  phase,
    output logic                clk7m,
    output logic                c1,
    output logic                c3,
    output logic                clk_en,
    output logic                cck,
    output logic                cck_en,
    output logic [ECLK_DIV-1:0] eclk,
    output logic                cpu_en,
    output logic                turbo_active
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int EW = $clog2(ECLK_DIV);

    localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_HALF  = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] P_Q1    = PW'(CLK_DIV / 4);
    localparam logic [PW-1:0] P_Q3    = PW'(3 * CLK_DIV / 4);
    localparam logic [EW-1:0] E_LAST  = EW'(ECLK_DIV - 1);

    // Phases at which turbo mode issues a CPU enable. Because TURBO_DIV divides
    // CLK_DIV, the last of these always lands on the clk_en phase.
    function automatic logic [CLK_DIV-1:0] turbo_mask();
        logic [CLK_DIV-1:0] m;
        m = '0;
        for (int k = 0; k < CLK_DIV; k++) begin
            m[k] = ((k % TURBO_DIV) == (TURBO_DIV - 1));
        end
        return m;
    endfunction

    localparam logic [CLK_DIV-1:0] TURBO_MASK = turbo_mask();

    // Elaboration-time parameter checks.
    generate
        if ((CLK_DIV < 4) || ((CLK_DIV % 4) != 0)) begin : g_bad_clk_div
            $error("clock_enable_sequencer: CLK_DIV must be a multiple of 4 and >= 4");
        end
        if ((ECLK_DIV < 2) || ((ECLK_DIV % 2) != 0)) begin : g_bad_eclk_div
            $error("clock_enable_sequencer: ECLK_DIV must be even and >= 2");
        end
        if ((TURBO_DIV < 1) || ((CLK_DIV % ((TURBO_DIV < 1) ? 1 : TURBO_DIV)) != 0)) begin : g_bad_turbo_div
            $error("clock_enable_sequencer: TURBO_DIV must be >= 1 and divide CLK_DIV");
        end
    endgenerate

    logic [PW-1:0] p;
    logic [EW-1:0] e_cnt;
    logic          mode;

    always_ff @(posedge clk28m) begin
        if (reset) begin
            p     <= '0;
            e_cnt <= '0;
            mode  <= 1'b0;
        end else begin
            p <= (p == P_LAST) ? '0 : p + PW'(1);
            // Mode and E counter only move on the bus-cycle boundary; the
            // clk_en pulse of this cycle was already issued under the old mode.
            if (clk_en) begin
                mode  <= turbo;
                e_cnt <= (e_cnt == E_LAST) ? '0 : e_cnt + EW'(1);
            end
        end
    end

    always_comb begin
        phase = '0;
        eclk  = '0;
        for (int k = 0; k < CLK_DIV; k++) begin
            phase[k] = (p == PW'(k));
        end
        for (int k = 0; k < ECLK_DIV; k++) begin
            eclk[k] = (e_cnt == EW'(k));
        end
        clk7m        = (p < P_HALF);
        c1           = (p < P_HALF);
        c3           = (p >= P_Q1) && (p < P_Q3);
        clk_en       = (p == P_LAST);
        cck          = ~e_cnt[0];
        cck_en       = (p == P_LAST) & e_cnt[0];
        turbo_active = mode;
    end

    assign cpu_en = mode ? |(phase & TURBO_MASK) : clk_en;

endmodule

// File: tb/tb_clock_enable_sequencer.sv
module tb_clock_enable_sequencer;

    localparam int CA = 4;
    localparam int EA = 10;
    localparam int TA = 2;
    localparam int CB = 8;
    localparam int EB = 6;
    localparam int TB = 4;

    logic clk28m = 1'b0;
    logic reset  = 1'b1;
    logic turbo  = 1'b0;

    always #5 clk28m = ~clk28m;

    logic [CA-1:0] phase_a;
    logic [EA-1:0] eclk_a;
    logic          clk7m_a, c1_a, c3_a, clk_en_a, cck_a, cck_en_a, cpu_en_a, ta_a;
    logic [CB-1:0] phase_b;
    logic [EB-1:0] eclk_b;
    logic          clk7m_b, c1_b, c3_b, clk_en_b, cck_b, cck_en_b, cpu_en_b, ta_b;

    clock_enable_sequencer #(.CLK_DIV(CA), .ECLK_DIV(EA), .TURBO_DIV(TA)) dut_a (
        .clk28m(clk28m), .reset(reset), .turbo(turbo),
        .phase(phase_a), .clk7m(clk7m_a), .c1(c1_a), .c3(c3_a), .clk_en(clk_en_a),
        .cck(cck_a), .cck_en(cck_en_a), .eclk(eclk_a), .cpu_en(cpu_en_a), .turbo_active(ta_a)
    );

    clock_enable_sequencer #(.CLK_DIV(CB), .ECLK_DIV(EB), .TURBO_DIV(TB)) dut_b (
        .clk28m(clk28m), .reset(reset), .turbo(turbo),
        .phase(phase_b), .clk7m(clk7m_b), .c1(c1_b), .c3(c3_b), .clk_en(clk_en_b),
        .cck(cck_b), .cck_en(cck_en_b), .eclk(eclk_b), .cpu_en(cpu_en_b), .turbo_active(ta_b)
    );

    logic [63:0] act_a, act_b;
    assign act_a = 64'({phase_a, clk7m_a, c1_a, c3_a, clk_en_a, cck_a, cck_en_a, eclk_a, cpu_en_a, ta_a});
    assign act_b = 64'({phase_b, clk7m_b, c1_b, c3_b, clk_en_b, cck_b, cck_en_b, eclk_b, cpu_en_b, ta_b});

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_tag = "reset";

    // Reference state: phase counter, E counter and mode per instance.
    int mpa = 0, mea = 0, mpb = 0, meb = 0;
    bit mma = 1'b0, mmb = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected output vector, packed in the same order as act_a/act_b.
    function automatic logic [63:0] expect_vec(input int c, input int e, input int t,
                                               input int p, input int ec, input bit m);
        logic [63:0] v;
        bit          ce;
        ce = (p == c - 1);
        v  = 64'd1 << p;
        v  = (v << 1) | 64'(p < c / 2);
        v  = (v << 1) | 64'(p < c / 2);
        v  = (v << 1) | 64'((p >= c / 4) && (p < 3 * c / 4));
        v  = (v << 1) | 64'(ce);
        v  = (v << 1) | 64'((ec % 2) == 0);
        v  = (v << 1) | 64'(ce && ((ec % 2) == 1));
        v  = (v << e) | (64'd1 << ec);
        v  = (v << 1) | 64'(m ? ((p % t) == t - 1) : ce);
        v  = (v << 1) | 64'(m);
        return v;
    endfunction

    task automatic model_adv(input int c, input int e, input bit r, input bit t,
                             inout int p, inout int ec, inout bit m);
        if (r) begin
            p  = 0;
            ec = 0;
            m  = 1'b0;
        end else if (p == c - 1) begin
            m  = t;
            ec = (ec == e - 1) ? 0 : ec + 1;
            p  = 0;
        end else begin
            p = p + 1;
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge.
    task automatic step(input bit r, input bit t);
        exp_t x;
        @(negedge clk28m);
        reset = r;
        turbo = t;
        model_adv(CA, EA, r, t, mpa, mea, mma);
        model_adv(CB, EB, r, t, mpb, meb, mmb);
        x.a   = expect_vec(CA, EA, TA, mpa, mea, mma);
        x.b   = expect_vec(CB, EB, TB, mpb, meb, mmb);
        x.tag = cur_tag;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        int   cyc      = 0;
        int   last_cpu = -1;
        int   run9     = 0;
        bit   prev_c1  = 1'b0;
        bit   prev_ok  = 1'b0;
        bit   prev_ta  = 1'b0;
        forever begin
            @(posedge clk28m);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk({x.tag, "_vec_a"}, act_a, x.a);
                chk({x.tag, "_vec_b"}, act_b, x.b);
                chk("eclk_a_onehot", 64'($onehot(eclk_a)), 64'd1);
                chk("eclk_b_onehot", 64'($onehot(eclk_b)), 64'd1);
                chk("phase_a_onehot", 64'($onehot(phase_a)), 64'd1);

                if (!reset && prev_ok) chk("c3_lags_c1", 64'(c3_a), 64'(prev_c1));
                prev_c1 = c1_a;
                prev_ok = 1'b1;

                if (reset) begin
                    last_cpu = -1;
                end else if (cpu_en_a) begin
                    if (last_cpu >= 0)
                        chk("cpu_gap_a_2to4", 64'(((cyc - last_cpu) >= 2) && ((cyc - last_cpu) <= 4)), 64'd1);
                    last_cpu = cyc;
                end

                if (ta_a && cpu_en_a)
                    chk("turbo_cpu_pos_a", 64'((phase_a == 4'b0010) || (phase_a == 4'b1000)), 64'd1);
                if (ta_b && cpu_en_b)
                    chk("turbo_cpu_pos_b", 64'((phase_b == 8'h08) || (phase_b == 8'h80)), 64'd1);

                if (ta_a != prev_ta) chk("mode_change_at_p0", 64'(phase_a), 64'h1);
                prev_ta = ta_a;

                if (eclk_a[EA-1]) begin
                    run9++;
                end else if (run9 > 0) begin
                    if (!reset) chk("eclk9_width", 64'(run9), 64'd4);
                    run9 = 0;
                end
            end
        end
    end

    initial begin : stim
        cur_tag = "reset";
        repeat (5) step(1'b1, 1'b0);

        cur_tag = "free_run";
        repeat (200) step(1'b0, 1'b0);

        // Raise turbo while p==1; mode must flip only after the p=3 boundary.
        cur_tag = "turbo_on";
        for (int i = 0; i < CA && mpa != 1; i++) step(1'b0, 1'b0);
        repeat (24) step(1'b0, 1'b1);

        // Drop turbo at p==2, then a one-cycle glitch at p==1 of the next bus cycle.
        cur_tag = "turbo_off";
        for (int i = 0; i < CA && mpa != 2; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < CA && mpa != 1; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (24) step(1'b0, 1'b0);

        // Single-cycle reset at e_cnt==7, p==2 while turbo is active.
        cur_tag = "mid_reset";
        for (int i = 0; i < CA * EA && !(mea == 7 && mpa == 2); i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        cur_tag = "restart";
        repeat (60) step(1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk28m);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
